// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: 3x3 round-robin burst arbiter; define ARB_STATS_EN for per-input grant counters
module rr_port_arbiter #(
  parameter int PKT_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        nempty1,
  input  logic        nempty2,
  input  logic        nempty3,
  output logic [1:0]  sel1,
  output logic [1:0]  sel2,
  output logic [1:0]  sel3,
  output logic        en1,
  output logic        en2,
  output logic        en3,
  output logic        rdreq1,
  output logic        rdreq2,
  output logic        rdreq3,
  output logic        busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] gcnt1,
  output logic [15:0] gcnt2,
  output logic [15:0] gcnt3
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  logic [31:0] data [3];
  logic [2:0]  ne, granted, has, adv;
  logic [2:0]  req [3];
  logic [0:0]  st [3];
  logic [1:0]  gi [3], last [3], pick [3];
  logic [7:0]  cnt [3];
  function automatic logic [1:0] dst(input logic [1:0] c);
    return c == 2'b01 ? 2'd0 : c == 2'b11 ? 2'd2 : 2'd1;
  endfunction
  assign data[0] = data1;
  assign data[1] = data2;
  assign data[2] = data3;
  assign ne = {nempty3, nempty2, nempty1};
  always_comb begin
    granted = '0;
    adv = '0;
    has = '0;
    for (int p = 0; p < 3; p++) begin
      req[p] = '0;
      pick[p] = 2'd0;
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++) begin
        granted[i] = granted[i] | (st[p] == XFER && gi[p] == 2'(i));
        adv[p] = adv[p] | (st[p] == XFER && gi[p] == 2'(i) && ne[i]);
      end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++)
        req[p][i] = ne[i] && |data[i] && dst(data[i][1:0]) == 2'(p) && !granted[i];
      has[p] = |req[p];
      for (int k = 2; k >= 0; k--)
        if (req[p][(int'(last[p]) + 1 + k) % 3]) pick[p] = 2'((int'(last[p]) + 1 + k) % 3);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int p = 0; p < 3; p++) begin
        st[p]   <= IDLE;
        gi[p]   <= 2'd0;
        cnt[p]  <= 8'd0;
        last[p] <= 2'd2;
      end
    else
      for (int p = 0; p < 3; p++)
        if (st[p] == IDLE) begin
          if (has[p]) begin
            st[p]  <= XFER;
            gi[p]  <= pick[p];
            cnt[p] <= 8'd0;
          end
        end else if (adv[p]) begin
          if (cnt[p] == 8'(PKT_WORDS - 1)) begin
            st[p]   <= IDLE;
            last[p] <= gi[p];
            cnt[p]  <= 8'd0;
          end else
            cnt[p] <= cnt[p] + 8'd1;
        end
  assign en1 = st[0] == XFER;
  assign en2 = st[1] == XFER;
  assign en3 = st[2] == XFER;
  assign sel1 = en1 ? gi[0] + 2'd1 : 2'b00;
  assign sel2 = en2 ? gi[1] + 2'd1 : 2'b00;
  assign sel3 = en3 ? gi[2] + 2'd1 : 2'b00;
  assign {rdreq3, rdreq2, rdreq1} = granted & ne;
  assign busy = en1 | en2 | en3;
`ifdef ARB_STATS_EN
  logic [2:0]  gev;
  logic [15:0] gc [3];
  always_comb begin
    gev = '0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++)
        gev[i] = gev[i] | (st[p] == IDLE && has[p] && pick[p] == 2'(i));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 3; i++) gc[i] <= 16'd0;
    else
      for (int i = 0; i < 3; i++)
        if (gev[i] && gc[i] != 16'hFFFF) gc[i] <= gc[i] + 16'd1;
  assign gcnt1 = gc[0];
  assign gcnt2 = gc[1];
  assign gcnt3 = gc[2];
`endif
endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter: vector table, burst corner sequences and randomized model comparison
module tb_rr_port_arbiter;
  localparam int PW = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data1 = '0, data2 = '0, data3 = '0;
  logic        nempty1 = 1'b0, nempty2 = 1'b0, nempty3 = 1'b0;
  logic [1:0]  sel1, sel2, sel3;
  logic        en1, en2, en3, rdreq1, rdreq2, rdreq3, busy;
`ifdef ARB_STATS_EN
  logic [15:0] gcnt1, gcnt2, gcnt3;
`endif
  logic [12:0] ov;
  int total = 0, bad = 0;
  int m_act[3], m_src[3], m_rem[3], m_last[3], m_g[3];
  typedef struct {
    logic        rst;
    logic [2:0]  ne;
    logic [31:0] d1, d2, d3;
    logic [5:0]  sel;
    logic [2:0]  en, rd;
    logic        b;
  } row_t;
  row_t tab[$];
  always #5 clk = ~clk;
  rr_port_arbiter #(.PKT_WORDS(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data1(data1), .data2(data2), .data3(data3),
    .nempty1(nempty1), .nempty2(nempty2), .nempty3(nempty3),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .en1(en1), .en2(en2), .en3(en3),
    .rdreq1(rdreq1), .rdreq2(rdreq2), .rdreq3(rdreq3),
    .busy(busy)
`ifdef ARB_STATS_EN
    , .gcnt1(gcnt1), .gcnt2(gcnt2), .gcnt3(gcnt3)
`endif
  );
  assign ov = {sel3, sel2, sel1, en3, en2, en1, rdreq3, rdreq2, rdreq1, busy};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [2:0] ne, input logic [31:0] d1, d2, d3);
    {nempty3, nempty2, nempty1} = ne;
    data1 = d1;
    data2 = d2;
    data3 = d3;
  endtask
  task automatic m_reset();
    for (int p = 0; p < 3; p++) begin
      m_act[p] = 0;
      m_src[p] = 0;
      m_rem[p] = 0;
      m_last[p] = 2;
      m_g[p] = 0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask
  function automatic int dest(input logic [31:0] d);
    return d[1:0] == 2'b01 ? 0 : d[1:0] == 2'b11 ? 2 : 1;
  endfunction
  function automatic logic [12:0] m_vec();
    logic [5:0] s;
    logic [2:0] e, r, ne;
    s = '0;
    e = '0;
    r = '0;
    ne = {nempty3, nempty2, nempty1};
    for (int p = 0; p < 3; p++)
      if (m_act[p] != 0) begin
        e[p] = 1'b1;
        s[2*p +: 2] = 2'(m_src[p] + 1);
        r[m_src[p]] = ne[m_src[p]];
      end
    return {s, e, r, |e};
  endfunction
  task automatic m_step();
    logic [31:0] d[3];
    logic [2:0] ne;
    int was[3], held[3];
    d[0] = data1;
    d[1] = data2;
    d[2] = data3;
    ne = {nempty3, nempty2, nempty1};
    for (int i = 0; i < 3; i++) held[i] = 0;
    for (int p = 0; p < 3; p++) begin
      was[p] = m_act[p];
      if (m_act[p] != 0) held[m_src[p]] = 1;
    end
    for (int p = 0; p < 3; p++)
      if (was[p] != 0) begin
        if (ne[m_src[p]]) begin
          m_rem[p]--;
          if (m_rem[p] == 0) begin
            m_act[p] = 0;
            m_last[p] = m_src[p];
          end
        end
      end else
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last[p] + k) % 3;
          if (m_act[p] == 0 && ne[c] && d[c] != 0 && held[c] == 0 && dest(d[c]) == p) begin
            m_act[p] = 1;
            m_src[p] = c;
            m_rem[p] = PW;
            m_g[c]++;
          end
        end
  endtask
  initial begin
    logic [7:0] sne, sen, srd;
    logic [31:0] rd[3];
    tab.push_back(row_t'{1'b1, 3'b001, 32'h1, 32'h0, 32'h0, 6'b000000, 3'b000, 3'b000, 1'b0});
    for (int i = 0; i < 4; i++)
      tab.push_back(row_t'{1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 6'b000001, 3'b001, 3'b001, 1'b1});
    tab.push_back(row_t'{1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 6'b000000, 3'b000, 3'b000, 1'b0});
    tab.push_back(row_t'{1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 6'b000001, 3'b001, 3'b001, 1'b1});
    tab.push_back(row_t'{1'b1, 3'b111, 32'h1, 32'h2, 32'h3, 6'b000000, 3'b000, 3'b000, 1'b0});
    tab.push_back(row_t'{1'b0, 3'b111, 32'h1, 32'h2, 32'h3, 6'b111001, 3'b111, 3'b111, 1'b1});
    tab.push_back(row_t'{1'b1, 3'b011, 32'h0, 32'h100, 32'h0, 6'b000000, 3'b000, 3'b000, 1'b0});
    tab.push_back(row_t'{1'b0, 3'b011, 32'h0, 32'h100, 32'h0, 6'b001000, 3'b010, 3'b010, 1'b1});
    foreach (tab[n]) begin
      if (tab[n].rst) do_reset();
      drive(tab[n].ne, tab[n].d1, tab[n].d2, tab[n].d3);
      #1;
      check($sformatf("row%0d", n), 32'(ov), 32'({tab[n].sel, tab[n].en, tab[n].rd, tab[n].b}));
      @(negedge clk);
    end
    do_reset();
    sne = 8'b11100111;
    sen = 8'b01111110;
    srd = 8'b01100110;
    for (int s = 0; s < 8; s++) begin
      drive({2'b00, sne[s]}, 32'h1, 0, 0);
      #1;
      check($sformatf("stall_en1_s%0d", s), 32'(en1), 32'(sen[s]));
      check($sformatf("stall_rd1_s%0d", s), 32'(rdreq1), 32'(srd[s]));
      @(negedge clk);
    end
    do_reset();
    for (int t = 0; t < 20; t++) begin
      int q, r;
      q = (t - 1) / 5;
      r = (t - 1) % 5;
      drive(3'b111, 32'h2, 32'h2, 32'h2);
      #1;
      check($sformatf("rr_sel2_t%0d", t), 32'(sel2), (t == 0 || r == 4) ? 0 : (q % 3) + 1);
      @(negedge clk);
    end
`ifdef ARB_STATS_EN
    check("gcnt1", 32'(gcnt1), 2);
    check("gcnt2", 32'(gcnt2), 1);
    check("gcnt3", 32'(gcnt3), 1);
`endif
    do_reset();
    drive(3'b111, 32'h2, 32'h2, 32'h2);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midburst_busy", 32'(busy), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'(ov), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(ov), 0);
    @(negedge clk);
    #1;
    check("tie_winner_sel2", 32'(sel2), 1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rd[i] = $urandom();
        if ($urandom_range(7) == 0) rd[i] = 0;
      end
      drive({$urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0}, rd[0], rd[1], rd[2]);
      #1;
      check("rand_outs", 32'(ov), 32'(m_vec()));
      m_step();
      @(negedge clk);
    end
`ifdef ARB_STATS_EN
    check("rand_gcnt1", 32'(gcnt1), m_g[0]);
    check("rand_gcnt2", 32'(gcnt2), m_g[1]);
    check("rand_gcnt3", 32'(gcnt3), m_g[2]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
